// File: rtl/count_checker_pkg.sv
// Shared definitions for the count checker: FSM encoding and default
// set/load values of the counter being observed.
package count_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAIL  = 2'd3
    } state_e;

    localparam logic [2:0] DEF_SET_VAL  = 3'b111;
    localparam logic [2:0] DEF_LOAD_VAL = 3'b100;

endpackage

// File: rtl/count_checker_model.sv
// Reference model of the counter under check. Holds the expected value and
// applies set > load > increment. In sync mode the observed count is used
// as the base so the model locks onto the counter in one step.
module count_model
    import count_checker_pkg::*;
#(
    parameter int              WIDTH    = 3,
    parameter logic [WIDTH-1:0] SET_VAL  = DEF_SET_VAL,
    parameter logic [WIDTH-1:0] LOAD_VAL = DEF_LOAD_VAL
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_i,
    input  logic             load_i,
    input  logic             sync_i,
    input  logic [WIDTH-1:0] count_i,
    output logic [WIDTH-1:0] exp_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] exp_q, exp_d, base;

    // Next expected value; base is the observed count while syncing
    always_comb begin
        base = sync_i ? count_i : exp_q;
        if (set_i)
            exp_d = SET_VAL;
        else if (load_i)
            exp_d = LOAD_VAL;
        else
            exp_d = base + 1'b1;
    end

    // Expected-value register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            exp_q <= '0;
        else
            exp_q <= exp_d;
    end

    // Increment out of all-ones; set/load never count as a wrap
    assign wrap_o = ~set_i & ~load_i & (exp_q == '1);
    assign exp_o  = exp_q;

endmodule

// File: rtl/count_checker.sv
// Checks a free-running counter against an internal model of it.
// Mismatches are reported as a delayed pulse, a sticky flag, a saturating
// count and the first offending expected/observed pair.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] SET_VAL     = DEF_SET_VAL,
    parameter logic [WIDTH-1:0] LOAD_VAL    = DEF_LOAD_VAL,
    parameter int               ERR_W       = 8,
    parameter int               STOP_ON_ERR = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             set,
    input  logic             load,
    input  logic [WIDTH-1:0] count,
    input  logic             clr_err,
    output logic             error,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got,
    output logic [ERR_W-1:0] wrap_cnt,
    output logic [1:0]       state
);

    state_e           state_q;
    logic [WIDTH-1:0] exp_val;
    logic             model_wrap;
    logic             mismatch;

    logic             error_q, error_d;
    logic             sticky_q, sticky_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] fexp_q, fexp_d;
    logic [WIDTH-1:0] fgot_q, fgot_d;
    logic [ERR_W-1:0] wrap_q, wrap_d;

    count_model #(
        .WIDTH    (WIDTH),
        .SET_VAL  (SET_VAL),
        .LOAD_VAL (LOAD_VAL)
    ) u_model (
        .clk_i   (clk),
        .rst_i   (reset),
        .set_i   (set),
        .load_i  (load),
        .sync_i  (state_q == ST_SYNC),
        .count_i (count),
        .exp_o   (exp_val),
        .wrap_o  (model_wrap)
    );

    assign mismatch = (state_q == ST_CHECK) && (count != exp_val);

    // Checker FSM; leaving CHECK on en=0 beats stopping on a mismatch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (en) state_q <= ST_SYNC;
                ST_SYNC:  state_q <= ST_CHECK;
                ST_CHECK: begin
                    if (!en)
                        state_q <= ST_IDLE;
                    else if (mismatch && (STOP_ON_ERR != 0))
                        state_q <= ST_FAIL;
                end
                ST_FAIL:  if (clr_err) state_q <= ST_SYNC;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Error status; a mismatch in the clearing cycle restarts the record
    always_comb begin
        error_d  = mismatch;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        fexp_d   = fexp_q;
        fgot_d   = fgot_q;
        wrap_d   = wrap_q;
        if (mismatch) begin
            sticky_d = 1'b1;
            if (clr_err)
                cnt_d = ERR_W'(1);
            else if (cnt_q != '1)
                cnt_d = cnt_q + 1'b1;
            if (clr_err || !sticky_q) begin
                fexp_d = exp_val;
                fgot_d = count;
            end
        end else if (clr_err) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
            fexp_d   = '0;
            fgot_d   = '0;
        end
        if ((state_q == ST_CHECK) && model_wrap)
            wrap_d = wrap_q + 1'b1;
    end

    // Status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            fexp_q   <= '0;
            fgot_q   <= '0;
            wrap_q   <= '0;
        end else begin
            error_q  <= error_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            fexp_q   <= fexp_d;
            fgot_q   <= fgot_d;
            wrap_q   <= wrap_d;
        end
    end

    assign error      = error_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;
    assign first_exp  = fexp_q;
    assign first_got  = fgot_q;
    assign wrap_cnt   = wrap_q;
    assign state      = state_q;

endmodule
